// File: rtl/uart_rx_core.sv
// Asynchronous serial receiver: synchronizer, start/data/stop framing, break hold; byte out one clock after stop sample.
// Latency ~SYNC_STAGES+1 clocks to start detect; no backpressure, rx_data_o is overwritten by each good frame.
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock_i,
    input  logic                 resetn_i,
    input  logic [11:0]          baud_div,
    input  logic                 rx_din_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_done,
    output logic                 rx_ing,
    output logic                 rx_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t                 state_q, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [11:0]            cnt_q, cnt_n;
    logic [11:0]            period_q, period_n;
    logic [3:0]             bit_q, bit_n;
    logic [DATA_BITS-1:0]   shreg_q, shreg_n;
    logic [DATA_BITS-1:0]   data_q, data_n;
    logic                   done_q, done_n;
    logic                   err_q, err_n;

    // Flops reset to idle-high so a line held low through reset is seen as a fresh edge.
    always_ff @(posedge clock_i or posedge resetn_i) begin
        if (resetn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_din_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_i or posedge resetn_i) begin
        if (resetn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= 12'd3;
            bit_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            period_q <= period_n;
            bit_q    <= bit_n;
            shreg_q  <= shreg_n;
            data_q   <= data_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q + 12'd1;
        period_n = period_q;
        bit_n    = bit_q;
        shreg_n  = shreg_q;
        data_n   = data_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n  = START;
                    // Period is frozen for the whole frame; very short periods are clamped.
                    period_n = (baud_div < 12'd3) ? 12'd3 : baud_div;
                end
            end
            START: begin
                if (cnt_q == (period_q >> 1)) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == period_q) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == period_q) begin
                    cnt_n = '0;
                    if (rxs) begin
                        data_n  = shreg_q;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rx_data_o = data_q;
    assign rx_done   = done_q;
    assign rx_err    = err_q;
    assign rx_ing    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framed bytes, false start, framing error, reset abort, baud change.
module tb_uart_rx_core;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic [11:0] baud_div;
    logic        rx_din_i;
    logic [7:0]  rx_data_o;
    logic        rx_done;
    logic        rx_ing;
    logic        rx_err;

    int n_tests = 0;
    int n_fail  = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int ing_cyc  = 0;
    logic [7:0] data_q[$];

    uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clock_i   (clock_i),
        .resetn_i  (resetn_i),
        .baud_div  (baud_div),
        .rx_din_i  (rx_din_i),
        .rx_data_o (rx_data_o),
        .rx_done   (rx_done),
        .rx_ing    (rx_ing),
        .rx_err    (rx_err)
    );

    always #5 clock_i = ~clock_i;

    always @(negedge clock_i) begin
        if (rx_done) begin
            done_cnt++;
            data_q.push_back(rx_data_o);
        end
        if (rx_err) err_cnt++;
        if (rx_done && rx_err) both_cnt++;
        if (rx_ing) ing_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line is changed 1 time unit after a rising edge and held for n whole clocks.
    task automatic drive_for(input logic v, input int n);
        rx_din_i = v;
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk,
                              input int chg_bit, input logic [11:0] chg_val);
        drive_for(1'b0, bclk);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) begin
                drive_for(d[i], bclk / 2);
                baud_div = chg_val;
                drive_for(d[i], bclk - bclk / 2);
            end else begin
                drive_for(d[i], bclk);
            end
        end
        drive_for(stop, bclk);
    endtask

    function automatic logic [7:0] q_at(input int idx);
        return (data_q.size() > idx) ? data_q[idx] : 8'hxx;
    endfunction

    int d0, e0, i0, b0;

    initial begin
        resetn_i = 1'b1;
        baud_div = 12'd86;
        rx_din_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check("reset_data", rx_data_o, 8'h00);
        check("reset_done", rx_done, 1'b0);
        check("reset_ing",  rx_ing,  1'b0);
        check("reset_err",  rx_err,  1'b0);
        @(posedge clock_i); #1;
        resetn_i = 1'b0;
        drive_for(1'b1, 20);

        // Good frame 0xA5 at 87 clocks/bit
        d0 = done_cnt; e0 = err_cnt; i0 = ing_cyc; b0 = data_q.size();
        send_frame(8'hA5, 1'b1, 87, -1, 12'd0);
        drive_for(1'b1, 100);
        check("a5_done_cnt", done_cnt - d0, 1);
        check("a5_data", rx_data_o, 8'hA5);
        check("a5_q", q_at(b0), 8'hA5);
        check("a5_err_cnt", err_cnt - e0, 0);
        check("a5_ing_len_ok", (ing_cyc - i0 >= 800) && (ing_cyc - i0 <= 880), 1'b1);

        // False start: 20 low clocks
        d0 = done_cnt; e0 = err_cnt; i0 = ing_cyc;
        drive_for(1'b0, 20);
        drive_for(1'b1, 200);
        check("glitch_ing_len_ok", (ing_cyc - i0 >= 40) && (ing_cyc - i0 <= 48), 1'b1);
        check("glitch_done_cnt", done_cnt - d0, 0);
        check("glitch_err_cnt", err_cnt - e0, 0);
        check("glitch_ing_low", rx_ing, 1'b0);

        // 0x11 good, then 0x3C with low stop and line held low
        send_frame(8'h11, 1'b1, 87, -1, 12'd0);
        drive_for(1'b1, 100);
        check("p11_data", rx_data_o, 8'h11);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 87, -1, 12'd0);
        drive_for(1'b0, 200);
        @(negedge clock_i);
        check("brk_ing_held", rx_ing, 1'b1);
        check("brk_err_cnt", err_cnt - e0, 1);
        check("brk_done_cnt", done_cnt - d0, 0);
        check("brk_data_kept", rx_data_o, 8'h11);
        @(posedge clock_i); #1;
        drive_for(1'b1, 6);
        @(negedge clock_i);
        check("brk_ing_released", rx_ing, 1'b0);
        drive_for(1'b1, 100);
        check("brk_err_total", err_cnt - e0, 1);

        // Back-to-back at the minimum period
        baud_div = 12'd3;
        drive_for(1'b1, 20);
        d0 = done_cnt; e0 = err_cnt; b0 = data_q.size();
        send_frame(8'h00, 1'b1, 4, -1, 12'd0);
        send_frame(8'hFF, 1'b1, 4, -1, 12'd0);
        drive_for(1'b1, 40);
        check("b2b_done_cnt", done_cnt - d0, 2);
        check("b2b_first", q_at(b0), 8'h00);
        check("b2b_second", q_at(b0 + 1), 8'hFF);
        check("b2b_err_cnt", err_cnt - e0, 0);

        // Reset in the middle of data bit 4, then a clean frame
        baud_div = 12'd86;
        drive_for(1'b1, 20);
        d0 = done_cnt; e0 = err_cnt;
        drive_for(1'b0, 87);
        for (int i = 0; i < 4; i++) drive_for(i[0], 87);
        drive_for(1'b0, 40);
        resetn_i = 1'b1;
        @(negedge clock_i);
        check("rst_mid_ing", rx_ing, 1'b0);
        check("rst_mid_data", rx_data_o, 8'h00);
        @(posedge clock_i); #1;
        resetn_i = 1'b0;
        drive_for(1'b1, 300);
        check("rst_abort_done", done_cnt - d0, 0);
        check("rst_abort_err", err_cnt - e0, 0);
        check("rst_after_data", rx_data_o, 8'h00);
        send_frame(8'h5A, 1'b1, 87, -1, 12'd0);
        drive_for(1'b1, 100);
        check("rst_next_data", rx_data_o, 8'h5A);
        check("rst_next_done", done_cnt - d0, 1);

        // baud_div changed mid-frame takes effect only on the next frame
        d0 = done_cnt; b0 = data_q.size();
        send_frame(8'hC3, 1'b1, 87, 2, 12'd20);
        drive_for(1'b1, 100);
        check("chg_c3", q_at(b0), 8'hC3);
        send_frame(8'h96, 1'b1, 21, -1, 12'd0);
        drive_for(1'b1, 60);
        check("chg_96", q_at(b0 + 1), 8'h96);
        check("chg_done_cnt", done_cnt - d0, 2);

        check("never_both", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth (legal 2..3).
REQ-003 SHALL have port clock_i  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port resetn_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port baud_div  input  12  bit period minus one, in clocks (86 = 87 clocks/bit).
REQ-006 SHALL have port rx_din_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data_o  output  DATA_BITS  last correctly framed byte, LSB = first data bit.
REQ-008 SHALL have port rx_done  output  1  one-cycle pulse, rx_data_o just updated.
REQ-009 SHALL have port rx_ing  output  1  high while a frame is being received.
REQ-010 SHALL have port rx_err  output  1  one-cycle pulse on framing error.

Function
REQ-011 SHALL pass rx_din_i through a SYNC_STAGES flop synchronizer; the synchronized line (rxs) is the only line used internally.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-013 SHALL latch bit period P = max(baud_div, 3) on leaving IDLE; baud_div changes mid-frame SHALL have no effect until the next frame.
REQ-014 SHALL keep bit counter cnt 0..P, reset to 0 on every state entry and every bit boundary; the mid-bit sample point is cnt == P>>1.
REQ-015 IDLE -> START on the first clock where rxs == 0; rx_ing SHALL rise in the same cycle the state becomes START.
REQ-016 START: at mid-sample, rxs == 0 -> cnt restarts at 0 and state becomes DATA; rxs == 1 -> false start, back to IDLE, no rx_err, no rx_done.
REQ-017 DATA: sample rxs at each cnt == P (one full period after the previous sample point), shifting LSB-first into a shift register; after DATA_BITS samples, state becomes STOP.
REQ-018 STOP: sample rxs at cnt == P; rxs == 1 -> rx_data_o <= shift register, rx_done = 1 in the next cycle, state becomes IDLE.
REQ-019 STOP sample rxs == 0 -> rx_data_o unchanged, rx_err = 1 in the next cycle, state becomes BREAK.
REQ-020 BREAK SHALL hold until rxs == 1, then go to IDLE; no new start is detected while in BREAK.
REQ-021 rx_ing SHALL be high in START, DATA, STOP and BREAK, and low in IDLE.
REQ-022 rx_done and rx_err SHALL each be high for exactly one clock per frame, and SHALL never be high together.
REQ-023 A start edge present in the same cycle as the return to IDLE SHALL be detected on the next clock, with no frame lost.
REQ-024 Back-to-back frames with one stop bit SHALL be received without loss at any legal P.

Reset
REQ-025 While resetn_i is high, all outputs SHALL be forced immediately: rx_data_o = 0, rx_done = 0, rx_ing = 0, rx_err = 0, state = IDLE, cnt = 0, shift register = 0, and all synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done and no rx_err.
REQ-027 After reset release, a line held low SHALL be treated as a start only after rxs is seen low.

Verification
REQ-028 baud_div=86, frame 0xA5 with stop=1 -> exactly one rx_done, rx_data_o=0xA5, rx_err never high, rx_ing high about 10x87 clocks.
REQ-029 baud_div=86, rx_din_i low for 20 clocks then high -> rx_ing high about 43 clocks, then low; no rx_done, no rx_err.
REQ-030 baud_div=86, prior byte 0x11, then 0x3C with stop=0 and line low 200 clocks -> one rx_err pulse, rx_data_o stays 0x11, rx_ing low only after line rises.
REQ-031 baud_div=3, frames 0x00 then 0xFF back-to-back -> two rx_done pulses, values 0x00 then 0xFF in order.
REQ-032 baud_div=86, resetn_i pulsed high during data bit 4, then frame 0x5A -> no pulse for the aborted frame; rx_data_o=0x00 after reset, then 0x5A.
REQ-033 baud_div changed 86->20 during data bit 2 of 0xC3 at 87 clocks/bit -> rx_data_o=0xC3; the next frame is received at 21 clocks/bit.
